pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline hazard and flush scheduler for the five-stage MIPS core. Drives the `keep` (stall) and `clr` (flush) inputs of the IF/ID, ID/EX, EX/MEM and MEM/WR pipeline registers, plus PC enable and PC source select. It arbitrates between memory wait, interrupt/ERET redirection, mult/div busy stalls and load-use stalls, and sequences multi-cycle MDU occupancy with an internal counter.

## Interface
- MULT_LAT, 5, cycles the MDU is busy after a mult issue (≥2)
- DIV_LAT, 10, cycles the MDU is busy after a div issue (≥2, ≤31)
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- mem_wait  in  1  data bus not ready; the whole pipeline must freeze
- load_use_D  in  1  ID instruction reads the destination of the load in EX
- md_start_E  in  1  mult/div in EX this cycle (valid only when not stalled)
- md_is_div_E  in  1  qualifies md_start_E: 1 = div, 0 = mult
- md_use_D  in  1  ID instruction is mfhi/mflo/mthi/mtlo/mult/div
- IntReq_M  in  1  interrupt taken on the MEM-stage instruction
- eret_M  in  1  ERET in MEM
- keep_FD, keep_DE, keep_EM, keep_MW  out  1  hold the corresponding register
- clr_FD, clr_DE, clr_EM, clr_MW  out  1  bubble the corresponding register
- pc_en  out  1  PC register update enable
- pc_sel  out  2  00 sequential/branch, 01 handler (0x4180), 10 EPC
- md_busy  out  1  MDU counter non-zero

## Operation
- State register: RUN, HOLD. Also tracked: md_cnt[4:0], int_pend, eret_pend.
- Priority, highest first: rst, HOLD/mem_wait freeze, redirect (interrupt/ERET), MDU stall, load-use stall.
- Freeze (mem_wait=1): all four keep=1, all clr=0, pc_en=0, pc_sel=00. State moves to HOLD. IntReq_M/eret_M seen during freeze set int_pend/eret_pend. md_cnt still decrements.
- Leaving HOLD (mem_wait=0): state returns to RUN. A pending flag is consumed as a redirect in that same cycle.
- Redirect (IntReq_M|int_pend, or eret_M|eret_pend, when not frozen): clr_FD=clr_DE=clr_EM=1, keep_*=0, pc_en=1. pc_sel=01 for an interrupt, 10 for ERET. Interrupt beats ERET; both pend flags clear. MEM/WR is not cleared, so the faulting instruction's EPC capture completes.
- MDU stall (md_use_D & (md_busy | md_start_E)): keep_FD=1, clr_DE=1, pc_en=0.
- Load-use stall: same outputs as the MDU stall.
- Otherwise: all keep/clr=0, pc_en=1, pc_sel=00.
- md_cnt:
  - Loads MULT_LAT or DIV_LAT on md_start_E outside a freeze.
  - Otherwise decrements when non-zero, saturating at 0.
  - Redirect does not cancel it; the MDU finishes.
- Invariant: keep_X and clr_X are never both 1. Checked by assertion.

## Timing
- All keep/clr/pc_en/pc_sel outputs are combinational from current state/flags and inputs, valid in the same cycle as the cause.
- md_busy is high for exactly LAT cycles starting the cycle after md_start_E, and is registered.
- Reset values: state=RUN, md_cnt=0, int_pend=eret_pend=0. With rst high, outputs are keep=0, clr=0, pc_en=1, pc_sel=00, md_busy=0.
- Redirect latency: handler PC is fetched the cycle after IntReq_M, or the cycle after mem_wait falls if deferred.
- Interrupt arriving while md_start_E is high: the counter still loads and the pipeline flushes.
- rst mid-MDU: counter cleared.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - Adds outputs stall_cnt[31:0], flush_cnt[31:0], freeze_cnt[31:0], all wrapping, reset to 0.
  - Counters increment once per cycle for MDU/load-use stall, redirect, and freeze respectively.
- PIPE_CTRL_PERF_EN undefined: ports and logic are absent.

## Structure
- Shared package `pipe_pkg`: pc_sel encodings (PC_SEQ, PC_HANDLER, PC_EPC), handler address 0x4180, FSM state type.
- One sub-module, `md_counter`: load/decrement/busy logic, parameterised by the two latencies.

## Test plan
- load_use_D=1 for one cycle → keep_FD=1, clr_DE=1, pc_en=0 that cycle. Next cycle all outputs back to 0/pc_en=1.
- md_start_E with md_is_div_E=1, then md_use_D held → md_busy high 10 cycles. Stall asserted through the last busy cycle, released the cycle md_busy falls.
- mem_wait high 3 cycles with IntReq_M pulsed in the 2nd → all keep=1 for 3 cycles. Next cycle: clr_FD/DE/EM=1, pc_sel=01, int_pend=0.
- IntReq_M and eret_M together with load_use_D → redirect only, pc_sel=01, clr_DE=1, keep_FD=0.
- rst asserted while md_cnt=4 → next cycle md_busy=0, state RUN. Outputs at reset values.
- PIPE_CTRL_PERF_EN build: 2 load-use stalls + 1 interrupt → stall_cnt=2, flush_cnt=1.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared encodings and state type for the pipeline hazard/flush scheduler
package pipe_pkg;
  localparam logic [1:0]  PC_SEQ       = 2'b00;
  localparam logic [1:0]  PC_HANDLER   = 2'b01;
  localparam logic [1:0]  PC_EPC       = 2'b10;
  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;
endpackage

// File: rtl/md_counter.sv
// rtl/md_counter.sv - MDU occupancy counter: loads the op latency on issue, counts down to zero
module md_counter
  import pipe_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic is_div,
  output logic busy
);
  logic [4:0] cnt;

  // A fresh issue reloads even if a previous op is still counting.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= 5'd0;
    else if (load)
      cnt <= is_div ? 5'(DIV_LAT) : 5'(MULT_LAT);
    else if (cnt != 5'd0)
      cnt <= cnt - 5'd1;
  end

  assign busy = (cnt != 5'd0);
endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - stall/flush scheduler for the five-stage core; PIPE_CTRL_PERF_EN adds event counters
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_wait,
  input  logic        load_use_D,
  input  logic        md_start_E,
  input  logic        md_is_div_E,
  input  logic        md_use_D,
  input  logic        IntReq_M,
  input  logic        eret_M,
  output logic        keep_FD,
  output logic        keep_DE,
  output logic        keep_EM,
  output logic        keep_MW,
  output logic        clr_FD,
  output logic        clr_DE,
  output logic        clr_EM,
  output logic        clr_MW,
  output logic        pc_en,
  output logic [1:0]  pc_sel,
  output logic        md_busy
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
  output logic [31:0] freeze_cnt
`endif
);
  state_t state, state_nxt;
  logic   int_pend, eret_pend, int_pend_nxt, eret_pend_nxt;
  logic   freeze, redirect, stall, busy_raw;

  md_counter #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) u_md_counter (
    .clk    (clk),
    .rst    (rst),
    .load   (md_start_E & ~mem_wait),
    .is_div (md_is_div_E),
    .busy   (busy_raw)
  );

  assign md_busy = busy_raw & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      int_pend  <= 1'b0;
      eret_pend <= 1'b0;
    end else begin
      state     <= state_nxt;
      int_pend  <= int_pend_nxt;
      eret_pend <= eret_pend_nxt;
    end
  end

  always_comb begin
    state_nxt     = RUN;
    int_pend_nxt  = 1'b0;
    eret_pend_nxt = 1'b0;
    freeze        = 1'b0;
    redirect      = 1'b0;
    stall         = 1'b0;
    keep_FD = 1'b0; keep_DE = 1'b0; keep_EM = 1'b0; keep_MW = 1'b0;
    clr_FD  = 1'b0; clr_DE  = 1'b0; clr_EM  = 1'b0; clr_MW  = 1'b0;
    pc_en   = 1'b1;
    pc_sel  = PC_SEQ;
    if (rst) begin
      state_nxt = RUN;
    end else if (mem_wait) begin
      freeze        = 1'b1;
      state_nxt     = HOLD;
      int_pend_nxt  = int_pend | IntReq_M;
      eret_pend_nxt = eret_pend | eret_M;
      keep_FD = 1'b1; keep_DE = 1'b1; keep_EM = 1'b1; keep_MW = 1'b1;
      pc_en   = 1'b0;
    end else if (IntReq_M | int_pend | eret_M | eret_pend) begin
      // MEM/WR is left alone so the faulting instruction still records EPC.
      redirect = 1'b1;
      clr_FD = 1'b1; clr_DE = 1'b1; clr_EM = 1'b1;
      pc_sel = (IntReq_M | int_pend) ? PC_HANDLER : PC_EPC;
    end else if ((md_use_D & (busy_raw | md_start_E)) | load_use_D) begin
      stall   = 1'b1;
      keep_FD = 1'b1;
      clr_DE  = 1'b1;
      pc_en   = 1'b0;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= 32'd0;
      flush_cnt  <= 32'd0;
      freeze_cnt <= 32'd0;
    end else begin
      if (stall)    stall_cnt  <= stall_cnt + 32'd1;
      if (redirect) flush_cnt  <= flush_cnt + 32'd1;
      if (freeze)   freeze_cnt <= freeze_cnt + 32'd1;
    end
  end
`endif

  // Pending redirects can only exist right after a freeze cycle.
  a_pend_only_in_hold: assert property (@(posedge clk) disable iff (rst)
    (state == RUN) |-> !(int_pend || eret_pend));
  a_keep_clr_excl: assert property (@(posedge clk) disable iff (rst)
    !((keep_FD && clr_FD) || (keep_DE && clr_DE) || (keep_EM && clr_EM) || (keep_MW && clr_MW)));
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl: vector table, corner sequences, random vs model
module tb_pipe_ctrl;
  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  localparam logic [7:0] I_RST = 8'h80, I_MW = 8'h40, I_LU = 8'h20, I_ST = 8'h10;
  localparam logic [7:0] I_DIV = 8'h08, I_USE = 8'h04, I_INT = 8'h02, I_ERET = 8'h01;

  localparam logic [11:0] O_IDLE  = 12'b0000_0000_1_00_0;
  localparam logic [11:0] O_STALL = 12'b1000_0100_0_00_0;
  localparam logic [11:0] O_FRZ   = 12'b1111_0000_0_00_0;
  localparam logic [11:0] O_RINT  = 12'b0000_1110_1_01_0;
  localparam logic [11:0] O_RERT  = 12'b0000_1110_1_10_0;
  localparam logic [11:0] B       = 12'b0000_0000_0_00_1;

  logic clk = 1'b0;
  logic rst, mem_wait, load_use_D, md_start_E, md_is_div_E, md_use_D, IntReq_M, eret_M;
  logic keep_FD, keep_DE, keep_EM, keep_MW, clr_FD, clr_DE, clr_EM, clr_MW, pc_en, md_busy;
  logic [1:0] pc_sel;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt, flush_cnt, freeze_cnt;
`endif

  always #5 clk = ~clk;

  pipe_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst(rst), .mem_wait(mem_wait), .load_use_D(load_use_D),
    .md_start_E(md_start_E), .md_is_div_E(md_is_div_E), .md_use_D(md_use_D),
    .IntReq_M(IntReq_M), .eret_M(eret_M),
    .keep_FD(keep_FD), .keep_DE(keep_DE), .keep_EM(keep_EM), .keep_MW(keep_MW),
    .clr_FD(clr_FD), .clr_DE(clr_DE), .clr_EM(clr_EM), .clr_MW(clr_MW),
    .pc_en(pc_en), .pc_sel(pc_sel), .md_busy(md_busy)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
`endif
  );

  wire [11:0] dut_out = {keep_FD, keep_DE, keep_EM, keep_MW, clr_FD, clr_DE, clr_EM, clr_MW,
                         pc_en, pc_sel, md_busy};

  int total = 0;
  int bad   = 0;

  // Reference model: MDU occupancy as "last busy cycle number", redirects as remembered requests.
  int cyc = 0;
  int md_last = -1;
  bit m_int, m_eret;
  int m_stall = 0, m_flush = 0, m_freeze = 0;

  function automatic logic [11:0] model_out(input logic [7:0] in);
    logic [11:0] busy;
    busy = (cyc <= md_last) ? B : 12'd0;
    if (in[7]) return O_IDLE;
    if (in[6]) return O_FRZ | busy;
    if (in[1] || m_int) return O_RINT | busy;
    if (in[0] || m_eret) return O_RERT | busy;
    if ((in[2] && (busy != 12'd0 || in[4])) || in[5]) return O_STALL | busy;
    return O_IDLE | busy;
  endfunction

  task automatic model_commit(input logic [7:0] in);
    bit busy;
    busy = (cyc <= md_last);
    if (in[7]) begin
      m_int = 0; m_eret = 0; md_last = cyc;
      m_stall = 0; m_flush = 0; m_freeze = 0;
    end else if (in[6]) begin
      m_int  = m_int  | in[1];
      m_eret = m_eret | in[0];
      m_freeze++;
    end else begin
      if (in[1] || m_int || in[0] || m_eret) begin
        m_flush++; m_int = 0; m_eret = 0;
      end else if ((in[2] && (busy || in[4])) || in[5]) begin
        m_stall++;
      end
      if (in[4]) md_last = cyc + (in[3] ? DIV_LAT : MULT_LAT);
    end
    cyc++;
  endtask

  task automatic apply(input logic [7:0] in);
    {rst, mem_wait, load_use_D, md_start_E, md_is_div_E, md_use_D, IntReq_M, eret_M} = in;
  endtask

  task automatic step(input logic [7:0] in, input logic [11:0] exp, input string nm);
    apply(in);
    @(negedge clk);
    total++;
    if (dut_out !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (in=%b)", nm, dut_out, exp, in);
    end
    model_commit(in);
    @(posedge clk);
    #1;
  endtask

  task automatic check32(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  typedef struct {
    logic [7:0]  in;
    logic [11:0] exp;
  } vec_t;
  vec_t tbl[23];

  initial begin
    tbl[0]  = '{I_RST, O_IDLE};
    tbl[1]  = '{I_LU, O_STALL};
    tbl[2]  = '{8'h00, O_IDLE};
    tbl[3]  = '{I_INT | I_ERET | I_LU, O_RINT};
    tbl[4]  = '{I_ERET, O_RERT};
    tbl[5]  = '{I_MW, O_FRZ};
    tbl[6]  = '{I_MW | I_INT, O_FRZ};
    tbl[7]  = '{I_MW, O_FRZ};
    tbl[8]  = '{8'h00, O_RINT};
    tbl[9]  = '{8'h00, O_IDLE};
    tbl[10] = '{I_ST, O_IDLE};
    tbl[11] = '{I_USE, O_STALL | B};
    tbl[12] = '{I_USE, O_STALL | B};
    tbl[13] = '{I_USE, O_STALL | B};
    tbl[14] = '{I_USE, O_STALL | B};
    tbl[15] = '{I_USE, O_STALL | B};
    tbl[16] = '{I_USE, O_IDLE};
    tbl[17] = '{I_MW | I_ERET | I_ST, O_FRZ};
    tbl[18] = '{I_USE, O_RERT};
    tbl[19] = '{I_ST | I_INT, O_RINT};
    tbl[20] = '{I_USE, O_STALL | B};
    tbl[21] = '{I_RST, O_IDLE};
    tbl[22] = '{I_USE, O_IDLE};

    apply(I_RST);
    @(posedge clk);
    #1;
    model_commit(I_RST);

    for (int i = 0; i < 23; i++) step(tbl[i].in, tbl[i].exp, $sformatf("vec%0d", i));

    // Divide with the consumer held in ID: stalled for exactly DIV_LAT cycles.
    step(I_ST | I_DIV, O_IDLE, "div_issue");
    for (int i = 0; i < DIV_LAT; i++) step(I_USE, O_STALL | B, $sformatf("div_busy%0d", i));
    step(I_USE, O_IDLE, "div_release");

    // Reset in the middle of a multiply.
    step(I_ST, O_IDLE, "mul_issue");
    step(8'h00, O_IDLE | B, "mul_cnt5");
    step(I_RST, O_IDLE, "mul_rst");
    step(I_USE, O_IDLE, "mul_after_rst");

`ifdef PIPE_CTRL_PERF_EN
    step(I_RST, O_IDLE, "perf_rst");
    step(I_LU, O_STALL, "perf_lu0");
    step(8'h00, O_IDLE, "perf_gap");
    step(I_LU, O_STALL, "perf_lu1");
    step(I_INT, O_RINT, "perf_int");
    check32("perf_stall", stall_cnt, 32'd2);
    check32("perf_flush", flush_cnt, 32'd1);
    check32("perf_freeze", freeze_cnt, 32'd0);
`endif

    for (int n = 0; n < 3000; n++) begin
      logic [7:0] in;
      in[7] = ($urandom_range(99) < 1);
      in[6] = ($urandom_range(99) < 20);
      in[5] = ($urandom_range(99) < 15);
      in[4] = ($urandom_range(99) < 10);
      in[3] = $urandom_range(1);
      in[2] = ($urandom_range(99) < 40);
      in[1] = ($urandom_range(99) < 5);
      in[0] = ($urandom_range(99) < 5);
      step(in, model_out(in), $sformatf("rand%0d", n));
    end

`ifdef PIPE_CTRL_PERF_EN
    check32("rand_stall_cnt", stall_cnt, m_stall);
    check32("rand_flush_cnt", flush_cnt, m_flush);
    check32("rand_freeze_cnt", freeze_cnt, m_freeze);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
